// File: rtl/rtc_multi_alarm_pkg.sv
// Shared types, calendar constants and calendar helpers for the multi-alarm RTC.
package rtc_pkg;

    localparam int SEC_PER_MIN   = 60;
    localparam int MIN_PER_HR    = 60;
    localparam int HRS_PER_DAY   = 24;
    localparam int DAYS_PER_WEEK = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_e;

    typedef struct packed {
        logic       en;
        logic [4:0] hr;
        logic [5:0] min;
        logic [6:0] dmask;
    } alarm_cfg_t;

    function automatic logic is_leap(input logic [31:0] y);
        return (((y % 32'd4) == 32'd0) && ((y % 32'd100) != 32'd0)) ||
               ((y % 32'd400) == 32'd0);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [31:0] y);
        case (m)
            4'd2:                      return is_leap(y) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/rtc_multi_alarm_if.sv
// Control/status bundle between the RTC core and its user (display, buttons, buzzer).
interface rtc_multi_alarm_if
    import rtc_pkg::*;
#(
    parameter int NA = 4,
    parameter int YW = 12
) ();
    localparam int SW = (NA > 1) ? $clog2(NA) : 1;

    // Every control input is a level or a one-clk strobe sampled on the rising clk edge;
    // there is no back-pressure, so a strobe is consumed in the cycle it is high.
    logic          tick;
    logic          timeset;
    logic          adv_min, adv_hr, adv_dow, adv_date, adv_mon, adv_yr;
    logic          alm_wr;
    logic [SW-1:0] alm_sel;
    logic [4:0]    alm_hr;
    logic [5:0]    alm_min;
    logic [6:0]    alm_dmask;
    logic          alm_en;
    logic          snooze;
    logic          dismiss;
    logic          alarm_on;

    logic [5:0]    sec, min;
    logic [4:0]    hr;
    logic [2:0]    dow;
    logic [4:0]    date;
    logic [3:0]    month;
    logic [YW-1:0] year;
    logic [NA-1:0] ringing;
    logic [NA-1:0] snoozed;
    logic          buzz;
    alarm_state_e  alm_state [NA];

    modport master (
        output tick, timeset, adv_min, adv_hr, adv_dow, adv_date, adv_mon, adv_yr,
        output alm_wr, alm_sel, alm_hr, alm_min, alm_dmask, alm_en,
        output snooze, dismiss, alarm_on,
        input  sec, min, hr, dow, date, month, year, ringing, snoozed, buzz, alm_state
    );

    modport slave (
        input  tick, timeset, adv_min, adv_hr, adv_dow, adv_date, adv_mon, adv_yr,
        input  alm_wr, alm_sel, alm_hr, alm_min, alm_dmask, alm_en,
        input  snooze, dismiss, alarm_on,
        output sec, min, hr, dow, date, month, year, ringing, snoozed, buzz, alm_state
    );

endinterface

// File: rtl/rtc_multi_alarm_alarm_channel.sv
// One alarm channel: config register, minute match, IDLE/RING/SNOOZE FSM and tick counter.
module alarm_channel
    import rtc_pkg::*;
#(
    parameter int SNOOZE_TICKS = 540,
    parameter int RING_TICKS   = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_i,
    input  logic         match_stb_i,
    input  logic [4:0]   hr_i,
    input  logic [5:0]   min_i,
    input  logic [2:0]   dow_i,
    input  logic         wr_i,
    input  alarm_cfg_t   cfg_i,
    input  logic         snooze_i,
    input  logic         dismiss_i,
    output logic         ringing_o,
    output logic         snoozed_o,
    output alarm_state_e state_o
);
    localparam int CMAX = (SNOOZE_TICKS > RING_TICKS) ? SNOOZE_TICKS : RING_TICKS;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] RING_LOAD = CW'(RING_TICKS);
    localparam logic [CW-1:0] SNZ_LOAD  = CW'(SNOOZE_TICKS);

    alarm_cfg_t   cfg_q, cfg_d;
    alarm_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         hit;
    logic         last_tick;

    assign hit = match_stb_i && cfg_q.en && (hr_i == cfg_q.hr) &&
                 (min_i == cfg_q.min) && cfg_q.dmask[dow_i];
    // One counter serves both states: ticks left until ring timeout or snooze expiry.
    assign last_tick = tick_i && (cnt_q <= CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_q   <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            cfg_q   <= cfg_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cfg_d   = cfg_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (wr_i) begin
            cfg_d   = cfg_i;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        state_d = RING;
                        cnt_d   = RING_LOAD;
                    end
                end
                RING: begin
                    if (dismiss_i) begin
                        state_d = IDLE;
                    end else if (snooze_i) begin
                        state_d = SNOOZE;
                        cnt_d   = SNZ_LOAD;
                    end else if (last_tick) begin
                        state_d = IDLE;
                    end else if (tick_i) begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                SNOOZE: begin
                    if (dismiss_i) begin
                        state_d = IDLE;
                    end else if (hit || last_tick) begin
                        state_d = RING;
                        cnt_d   = RING_LOAD;
                    end else if (tick_i) begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ringing_o = (state_q == RING);
    assign snoozed_o = (state_q == SNOOZE);
    assign state_o   = state_q;

endmodule

// File: rtl/rtc_multi_alarm.sv
// Calendar timekeeping core with NA independent alarm channels and a gated buzzer output.
module rtc_multi_alarm
    import rtc_pkg::*;
#(
    parameter int NA         = 4,
    parameter int YW         = 12,
    parameter int YEAR0      = 2024,
    parameter int SNOOZE_MIN = 9,
    parameter int RING_SEC   = 60
) (
    input logic              clk,
    input logic              rst,
    rtc_multi_alarm_if.slave bus
);
    localparam logic [5:0] SEC_MAX = 6'(SEC_PER_MIN - 1);
    localparam logic [5:0] MIN_MAX = 6'(MIN_PER_HR - 1);
    localparam logic [4:0] HR_MAX  = 5'(HRS_PER_DAY - 1);
    localparam logic [2:0] DOW_MAX = 3'(DAYS_PER_WEEK - 1);

    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic [4:0]    hr_q, hr_d;
    logic [2:0]    dow_q, dow_d;
    logic [4:0]    date_q, date_d;
    logic [3:0]    month_q, month_d;
    logic [YW-1:0] year_q, year_d;
    logic          match_q, match_d;
    logic [4:0]    dim_cur, dim_new;

    assign dim_cur = days_in_month(month_q, 32'(year_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_q   <= '0;
            min_q   <= '0;
            hr_q    <= '0;
            dow_q   <= '0;
            date_q  <= 5'd1;
            month_q <= 4'd1;
            year_q  <= YW'(YEAR0);
            match_q <= 1'b0;
        end else begin
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            dow_q   <= dow_d;
            date_q  <= date_d;
            month_q <= month_d;
            year_q  <= year_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        dow_d   = dow_q;
        date_d  = date_q;
        month_d = month_q;
        year_d  = year_q;
        match_d = 1'b0;
        dim_new = dim_cur;
        if (!bus.timeset) begin
            if (bus.tick) begin
                // Flags the arrival at hh:mm:00 so channels compare against the new time next cycle.
                match_d = (sec_q == SEC_MAX);
                if (sec_q != SEC_MAX) begin
                    sec_d = sec_q + 6'd1;
                end else begin
                    sec_d = '0;
                    if (min_q != MIN_MAX) begin
                        min_d = min_q + 6'd1;
                    end else begin
                        min_d = '0;
                        if (hr_q != HR_MAX) begin
                            hr_d = hr_q + 5'd1;
                        end else begin
                            hr_d  = '0;
                            dow_d = (dow_q == DOW_MAX) ? 3'd0 : dow_q + 3'd1;
                            if (date_q < dim_cur) begin
                                date_d = date_q + 5'd1;
                            end else begin
                                date_d = 5'd1;
                                if (month_q != 4'd12) begin
                                    month_d = month_q + 4'd1;
                                end else begin
                                    month_d = 4'd1;
                                    year_d  = year_q + YW'(1);
                                end
                            end
                        end
                    end
                end
            end
        end else begin
            if (bus.adv_min)  min_d   = (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
            if (bus.adv_hr)   hr_d    = (hr_q == HR_MAX) ? 5'd0 : hr_q + 5'd1;
            if (bus.adv_dow)  dow_d   = (dow_q == DOW_MAX) ? 3'd0 : dow_q + 3'd1;
            if (bus.adv_date) date_d  = (date_q >= dim_cur) ? 5'd1 : date_q + 5'd1;
            if (bus.adv_mon)  month_d = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
            if (bus.adv_yr)   year_d  = year_q + YW'(1);
            dim_new = days_in_month(month_d, 32'(year_d));
            if (date_d > dim_new) date_d = dim_new;
        end
    end

    alarm_cfg_t   wr_cfg;
    logic [NA-1:0] ring_w, snz_w;
    alarm_state_e st_w [NA];

    assign wr_cfg = '{en: bus.alm_en, hr: bus.alm_hr, min: bus.alm_min, dmask: bus.alm_dmask};

    for (genvar g = 0; g < NA; g++) begin : g_ch
        alarm_channel #(
            .SNOOZE_TICKS (SNOOZE_MIN * SEC_PER_MIN),
            .RING_TICKS   (RING_SEC)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick_i      (bus.tick),
            .match_stb_i (match_q),
            .hr_i        (hr_q),
            .min_i       (min_q),
            .dow_i       (dow_q),
            .wr_i        (bus.alm_wr && (int'(bus.alm_sel) == g)),
            .cfg_i       (wr_cfg),
            .snooze_i    (bus.snooze),
            .dismiss_i   (bus.dismiss),
            .ringing_o   (ring_w[g]),
            .snoozed_o   (snz_w[g]),
            .state_o     (st_w[g])
        );
    end

    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.hr        = hr_q;
    assign bus.dow       = dow_q;
    assign bus.date      = date_q;
    assign bus.month     = month_q;
    assign bus.year      = year_q;
    assign bus.ringing   = ring_w;
    assign bus.snoozed   = snz_w;
    assign bus.buzz      = (|ring_w) & bus.alarm_on;
    assign bus.alm_state = st_w;

endmodule

// File: doc/rtc_multi_alarm.md
# rtc_multi_alarm

- Next-generation timekeeping core: seconds, minutes, hours, day-of-week, date, month and year counters with a true leap-year calendar.
- Provides `NA` independent alarms. Each alarm has a day-of-week mask, snooze, dismiss and auto-silence.
- Runs in the single system clock domain and advances on a 1 Hz strobe.
- Feeds the existing display decoders and buzzer output at top level.

## Interface
Parameters:
- `NA`, 4, number of alarm channels (1..8)
- `YW`, 12, year counter width
- `YEAR0`, 2024, year loaded at reset
- `SNOOZE_MIN`, 9, snooze length in minutes
- `RING_SEC`, 60, ticks before a ringing alarm auto-silences

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `tick`  in  1  1 Hz strobe; one `clk` cycle wide.
- `timeset`  in  1  manual time-set mode; freezes timekeeping.
- `adv_min`, `adv_hr`, `adv_dow`, `adv_date`, `adv_mon`, `adv_yr`  in  1 each  single-cycle advance strobes; honoured only while `timeset`=1.
- `alm_wr`  in  1  write one alarm channel.
- `alm_sel`  in  $clog2(NA) (min 1)  channel to write.
- `alm_hr`  in  5  alarm hour, 0..23.
- `alm_min`  in  6  alarm minute, 0..59.
- `alm_dmask`  in  7  day mask; bit d enables day-of-week d (Sunday=0).
- `alm_en`  in  1  channel enable.
- `snooze`  in  1  strobe; applies to every ringing channel.
- `dismiss`  in  1  strobe; applies to every ringing or snoozed channel.
- `alarm_on`  in  1  global buzzer gate.
- `sec`, `min`  out  6  current seconds/minutes.
- `hr`  out  5  current hour.
- `dow`  out  3  day-of-week.
- `date`  out  5  day of month, 1..31.
- `month`  out  4  month, 1..12.
- `year`  out  YW  current year.
- `ringing`  out  NA  per-channel ring state.
- `snoozed`  out  NA  per-channel snooze state.
- `buzz`  out  1  = |`ringing` & `alarm_on`; the only combinational output.

## Operation
- Reset values: 00:00:00, `dow`=0, `date`=1, `month`=1, `year`=YEAR0. All alarm configs cleared (disabled, 00:00, mask 0). All channels IDLE.
- Timekeeping (`tick`=1, `timeset`=0):
  - `sec` wraps 59→0 and carries to `min`, 59→0 carries to `hr`, 23→0 carries to the day.
  - A day carry advances `dow` (6→0) and `date`.
  - `date` wraps from `days_in_month(month, year)` to 1 and carries to `month`; 12→1 carries to `year`. `year` wraps modulo 2^YW.
- Leap rule: (y%4==0 && y%100!=0) || y%400==0. February has 29 days in leap years, 28 otherwise. Months 4, 6, 9 and 11 have 30 days; all other months have 31.
- Manual mode (`timeset`=1):
  - `sec` holds. Each adv strobe increments its field by one with wrap and without carry.
  - `adv_date` wraps at the current month length.
  - After `adv_mon` or `adv_yr`, `date` clamps to the new month length when it exceeds it.
  - Simultaneous strobes are all applied; the clamp uses the final month/year.
- Alarm write: `alm_wr` loads the config into channel `alm_sel` and forces that channel to IDLE the same edge. Writes outside `timeset` are legal.
- Match condition for a channel: the time registers change to hh:mm:00 via `tick` with `timeset`=0, `alm_en`=1, hr/min equal to the config, and `alm_dmask[dow]`=1. Manual advance never matches. A match is evaluated once per minute.
- Per-channel FSM:
  - IDLE → RING on match; the ring counter clears.
  - RING → IDLE after RING_SEC ticks, on `dismiss`, or on a config write.
  - RING → SNOOZE on `snooze`; the snooze counter loads SNOOZE_MIN×60.
  - SNOOZE → RING when the counter reaches 0 on a tick, or on a fresh match.
  - SNOOZE → IDLE on `dismiss` or a config write.
- Priority: reset > config write > `dismiss` > `snooze` > match/timeout.
- `ringing` = (state==RING); `snoozed` = (state==SNOOZE).

## Timing
- Time outputs update on the edge where `tick`=1, i.e. one cycle of latency.
- A manual adv strobe takes effect at that edge.
- `ringing` rises one `clk` after the time registers show the matching hh:mm:00.
- Snooze/dismiss take effect at the strobe edge.
- Ring and snooze counters count ticks only.
- Asserting `rst` mid-ring or mid-snooze clears all state immediately, with no clock needed.

## Structure
- Package `rtc_pkg`:
  - `alarm_state_e` enum (IDLE, RING, SNOOZE)
  - `alarm_cfg_t` struct (en, hr, min, dmask)
  - functions `is_leap` and `days_in_month`
  - constants SEC_PER_MIN=60, HRS_PER_DAY=24, DAYS_PER_WEEK=7
- Sub-module `alarm_channel`: one config register, the match compare, the FSM and the ring/snooze counters. Instanced NA times from a generate loop.

## Test plan
- Reset release → 00:00:00, `dow`=0, 1/1/2024, `ringing`=0, `buzz`=0.
- Calendar rollovers, each followed by one tick from 23:59:59:
  - 2024-02-28 → 02-29
  - 2024-02-29 → 03-01
  - 2100-02-28 → 03-01
  - 2000-02-28 → 02-29
  - 2024-12-31 → 2025-01-01 with `dow` advancing
- Channel 0 set to 07:30 with mask 7'b0000010 (Monday):
  - reaching 07:30:00 on Monday → `ringing[0]`=1 next cycle and `buzz`=1 if `alarm_on`=1
  - same time on Tuesday → no ring
- Ringing channel:
  - `snooze` → `snoozed[0]`=1; 540 ticks later `ringing[0]`=1
  - `dismiss` → IDLE
  - untouched ring → IDLE after 60 ticks
- Date 31 Jan 2024 with `timeset`=1:
  - `adv_mon` → Feb 29
  - `adv_yr` → 2025, date 28
- `rst` low while two channels are ringing → all outputs return to reset values asynchronously, and no ring occurs after release until the next match.
